multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the multicycle RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal). The core shares one memory and one ALU across cycles. This block sequences them with a Moore FSM, one instruction every 3–5 cycles. It drives all datapath enables and mux selects. It reuses the existing AluDecoder for ALUControl.

Parameters:
None. Encodings are fixed constants in the shared package.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high
op  in  7  Instr[6:0], valid from IR after Fetch
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
ALUControl  out  3  from AluDecoder(funct7b5, op[5], funct3, ALUOp)
Illegal  out  1  one-cycle pulse in Decode for an unsupported op
Retire  out  1  one-cycle pulse in an instruction's last state

Behaviour:
- Reset:
  - Reset is a synchronous clock-edge event: state <= FETCH.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite, Illegal and Retire are forced to 0.
  - The first cycle after reset deasserts is FETCH.
  - Reset mid-instruction abandons the instruction; no write occurs in the reset cycle.
- Outputs not listed for a state are 0. PCUpdate, Branch and ALUOp are internal. ALUOp: 00=add, 01=sub, 10=funct-decoded.
- States and Moore outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00
  - MEMREAD: ResultSrc=00, AdrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1, Retire=1
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, Retire=1
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
  - ALUWB: ResultSrc=00, RegWrite=1, Retire=1
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, Retire=1
- PCWrite = PCUpdate | (Branch & Zero). This is the only Zero-dependent output and is combinational within BEQ.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH with Illegal=1; nothing is written, PC already advanced by 4
  - MEMADR: op=0000011 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Cycle counts: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- ImmSrc is combinational from op in every state:
  - 0000011 or 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - otherwise 00
- ALUControl is combinational from ALUOp and the instruction fields. No pipeline registers inside the block.
- Illegal encodings of the state register (beyond 11 states) -> next state FETCH, all enables 0.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit)
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
  - ALUOp constants
  - ResultSrc, ALUSrcA and ALUSrcB select constants
- One sub-module, mc_main_fsm: state register, next-state logic, Moore outputs, ALUOp.
- The top level adds the PCWrite gating, the ImmSrc decoder and an AluDecoder instance.

Test Plan:
- reset high 3 cycles, then release with op=0110011 -> during reset all write enables 0; then FETCH (IRWrite=1, PCWrite=1), DECODE, EXECUTER, ALUWB (RegWrite=1, Retire=1), back to FETCH.
- lw (op=0000011, funct3=010) -> 5-cycle sequence; MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1; ALUControl=000 in MEMADR.
- sw (op=0100011) -> ImmSrc=01; MEMWRITE has MemWrite=1, AdrSrc=1; RegWrite never 1; 4 cycles.
- beq (op=1100011) with Zero=1, then with Zero=0 -> BEQ state PCWrite=1 then 0; ALUControl=001; 3 cycles each.
- R-type sub (funct3=000, funct7b5=1) -> EXECUTER ALUControl=001; add with funct7b5=0 -> 000; jal -> JAL state PCWrite=1, ImmSrc=11, then ALUWB RegWrite=1.
- op=1111111 in DECODE -> Illegal=1 for one cycle, next FETCH, no RegWrite/MemWrite; reset asserted in MEMWRITE -> MemWrite=0 that cycle, next state FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALUOp codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: imm_src_of = IMM_I;
      OP_SW:       imm_src_of = IMM_S;
      OP_BEQ:      imm_src_of = IMM_B;
      OP_JAL:      imm_src_of = IMM_J;
      default:     imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to the 3-bit ALU control.
module alu_decoder
  import mc_pkg::*;
(
  input  logic       funct7b5,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  // Fixed add/sub for address and branch work, funct-decoded for ALU ops.
  always_comb begin
    // NOTE: every output gets a value before the case so no path can infer a latch.
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_ADD: alu_control = 3'b000;
      ALUOP_SUB: alu_control = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 && op5) ? 3'b001 : 3'b000; // sub only for R-type
          3'b010:  alu_control = 3'b101; // slt
          3'b110:  alu_control = 3'b011; // or
          3'b111:  alu_control = 3'b010; // and
          default: alu_control = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main Moore FSM of the multicycle controller: state register, next-state
// logic, per-state datapath controls and ALUOp.
module mc_main_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       pc_update,
  output logic       branch,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       retire
);

  state_e state_q, state_d;

  // State register; a synchronous reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore outputs; reset forces all write enables low.
  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        adr_src    = 1'b0;
        ir_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target computed early into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        // Return address PC+4 is formed from OldPC while PC takes the target.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH; // corrupted encoding: recover with everything off
    endcase

    if (reset) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller top: main FSM, PC write gating, immediate
// format decode and ALU decoder.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic       Retire
);

  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

  mc_main_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .pc_update  (pc_update),
    .branch     (branch),
    .adr_src    (AdrSrc),
    .mem_write  (MemWrite),
    .ir_write   (IRWrite),
    .reg_write  (RegWrite),
    .result_src (ResultSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .alu_op     (alu_op),
    .illegal    (Illegal),
    .retire     (Retire)
  );

  alu_decoder u_alu_dec (
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .funct3      (funct3),
    .alu_op      (alu_op),
    .alu_control (ALUControl)
  );

  // PC advances unconditionally on pc_update, or in BEQ when operands match.
  always_comb begin
    PCWrite = pc_update | (branch & Zero);
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    ImmSrc = imm_src_of(op);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus
// cycle-count sequences per instruction class.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .Illegal    (Illegal),
    .Retire     (Retire)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       ill;
    logic       ret;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] aluc;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    outs_t      exp;
  } vec_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  vec_t  vecs[$];
  outs_t act;
  int    passed = 0;
  int    total  = 0;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic outs_t o(input logic pcw, adr, mw, irw, rw, ill, ret,
                              input logic [1:0] rs, sa, sb, imm, input logic [2:0] aluc);
    o = {pcw, adr, mw, irw, rw, ill, ret, rs, sa, sb, imm, aluc};
  endfunction

  // Expected outputs of each state, written out from the state table.
  function automatic outs_t e_fetch(input logic [1:0] imm);
    e_fetch = o(1,0,0,1,0,0,0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
  endfunction
  function automatic outs_t e_decode(input logic [1:0] imm, input logic ill);
    e_decode = o(0,0,0,0,0,ill,0, 2'b00, 2'b01, 2'b01, imm, 3'b000);
  endfunction
  function automatic outs_t e_memadr(input logic [1:0] imm);
    e_memadr = o(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, imm, 3'b000);
  endfunction
  function automatic outs_t e_memread(input logic [1:0] imm);
    e_memread = o(0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic outs_t e_memwb(input logic [1:0] imm);
    e_memwb = o(0,0,0,0,1,0,1, 2'b01, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic outs_t e_memwrite(input logic [1:0] imm);
    e_memwrite = o(0,1,1,0,0,0,1, 2'b00, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic outs_t e_exec(input logic [1:0] imm, input logic is_r, input logic [2:0] aluc);
    e_exec = o(0,0,0,0,0,0,0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01, imm, aluc);
  endfunction
  function automatic outs_t e_jal(input logic [1:0] imm);
    e_jal = o(1,0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, imm, 3'b000);
  endfunction
  function automatic outs_t e_aluwb(input logic [1:0] imm);
    e_aluwb = o(0,0,0,0,1,0,1, 2'b00, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic outs_t e_beq(input logic z);
    e_beq = o(z,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
  endfunction

  task automatic add(input logic rst, input logic [6:0] op_i, input logic [2:0] f3,
                     input logic f7, input logic z, input outs_t exp);
    vec_t v;
    v.rst = rst; v.op = op_i; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Counts cycles from FETCH to the Retire pulse and records any writes seen.
  task automatic run_instr(input string name, input logic [6:0] op_i, input logic [2:0] f3,
                           input int exp_cycles, input logic exp_rw, input logic exp_mw);
    int   n;
    logic rw_seen, mw_seen;
    bit   done;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; op = op_i; funct3 = f3; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    check({name, "_fetch_irwrite"}, IRWrite, 1);
    n = 0; done = 0; rw_seen = 0; mw_seen = 0;
    for (int c = 1; c <= 10 && !done; c++) begin
      if (c > 1) begin
        @(negedge clk);
        #1;
      end
      rw_seen |= RegWrite;
      mw_seen |= MemWrite;
      if (Retire) begin
        n = c;
        done = 1;
      end
    end
    check({name, "_cycles"}, n, exp_cycles);
    check({name, "_regwrite_seen"}, rw_seen, exp_rw);
    check({name, "_memwrite_seen"}, mw_seen, exp_mw);
  endtask

  initial begin
    reset = 1'b1; op = RT; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;

    // Reset held three cycles: state FETCH, every write enable forced off.
    for (int i = 0; i < 3; i++)
      add(1, RT, 3'b000, 0, 0, o(0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    // R-type add
    add(0, RT, 3'b000, 0, 0, e_fetch(2'b00));
    add(0, RT, 3'b000, 0, 0, e_decode(2'b00, 0));
    add(0, RT, 3'b000, 0, 0, e_exec(2'b00, 1, 3'b000));
    add(0, RT, 3'b000, 0, 0, e_aluwb(2'b00));
    // R-type sub
    add(0, RT, 3'b000, 1, 0, e_fetch(2'b00));
    add(0, RT, 3'b000, 1, 0, e_decode(2'b00, 0));
    add(0, RT, 3'b000, 1, 0, e_exec(2'b00, 1, 3'b001));
    add(0, RT, 3'b000, 1, 0, e_aluwb(2'b00));
    // lw
    add(0, LW, 3'b010, 0, 0, e_fetch(2'b00));
    add(0, LW, 3'b010, 0, 0, e_decode(2'b00, 0));
    add(0, LW, 3'b010, 0, 0, e_memadr(2'b00));
    add(0, LW, 3'b010, 0, 0, e_memread(2'b00));
    add(0, LW, 3'b010, 0, 0, e_memwb(2'b00));
    // sw
    add(0, SW, 3'b010, 0, 0, e_fetch(2'b01));
    add(0, SW, 3'b010, 0, 0, e_decode(2'b01, 0));
    add(0, SW, 3'b010, 0, 0, e_memadr(2'b01));
    add(0, SW, 3'b010, 0, 0, e_memwrite(2'b01));
    // addi with funct7b5=1 must still add (not an R-type)
    add(0, IT, 3'b000, 1, 0, e_fetch(2'b00));
    add(0, IT, 3'b000, 1, 0, e_decode(2'b00, 0));
    add(0, IT, 3'b000, 1, 0, e_exec(2'b00, 0, 3'b000));
    add(0, IT, 3'b000, 1, 0, e_aluwb(2'b00));
    // beq taken, then not taken
    add(0, BQ, 3'b000, 0, 1, e_fetch(2'b10));
    add(0, BQ, 3'b000, 0, 1, e_decode(2'b10, 0));
    add(0, BQ, 3'b000, 0, 1, e_beq(1));
    add(0, BQ, 3'b000, 0, 0, e_fetch(2'b10));
    add(0, BQ, 3'b000, 0, 0, e_decode(2'b10, 0));
    add(0, BQ, 3'b000, 0, 0, e_beq(0));
    // jal
    add(0, JL, 3'b000, 0, 0, e_fetch(2'b11));
    add(0, JL, 3'b000, 0, 0, e_decode(2'b11, 0));
    add(0, JL, 3'b000, 0, 0, e_jal(2'b11));
    add(0, JL, 3'b000, 0, 0, e_aluwb(2'b11));
    // unsupported op: Illegal in DECODE, then straight back to FETCH
    add(0, BAD, 3'b000, 0, 0, e_fetch(2'b00));
    add(0, BAD, 3'b000, 0, 0, e_decode(2'b00, 1));
    // next fetch brings in a sw; reset lands in MEMWRITE and kills the write
    add(0, SW, 3'b010, 0, 0, e_fetch(2'b01));
    add(0, SW, 3'b010, 0, 0, e_decode(2'b01, 0));
    add(0, SW, 3'b010, 0, 0, e_memadr(2'b01));
    add(1, SW, 3'b010, 0, 0, o(0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    add(0, SW, 3'b010, 0, 0, e_fetch(2'b01));
    add(0, SW, 3'b010, 0, 0, e_decode(2'b01, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3;
      funct7b5 = vecs[i].f7; Zero = vecs[i].z;
      #1;
      check($sformatf("vec%0d_op%b_rst%0d", i, vecs[i].op, vecs[i].rst), act, vecs[i].exp);
    end

    // Instruction latency and write-enable exposure per class.
    run_instr("lw",   LW, 3'b010, 5, 1, 0);
    run_instr("sw",   SW, 3'b010, 4, 0, 1);
    run_instr("rtype", RT, 3'b000, 4, 1, 0);
    run_instr("itype", IT, 3'b000, 4, 1, 0);
    run_instr("jal",  JL, 3'b000, 4, 1, 0);
    run_instr("beq",  BQ, 3'b000, 3, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
